// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions.
// Instruction codes and fetch-stage state encoding.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack for fetch prediction.
// Circular buffer; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW:0]       cnt;
  logic [PW-1:0]     ptr_inc;

  assign ptr_inc = ptr + 1'b1;
  assign top     = mem[ptr];
  assign empty   = (cnt == '0);

  // Pointer and saturating occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (cnt != FULL) cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[ptr_inc] <= din;
  end

endmodule

// File: rtl/pc_select_pred.sv
// Fetch PC selection with jump/return prediction.
// Holds pred_pc, the RUN/HALT state and the correction mux.
module pc_select_pred
  import y86_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_stall,
  input  logic [3:0]        f_icode,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  input  logic [3:0]        m_icode,
  input  logic              m_cnd,
  input  logic [ADDR_W-1:0] m_valA,
  input  logic [3:0]        w_icode,
  input  logic [ADDR_W-1:0] w_valM,
  input  logic              w_pred_valid,
  input  logic [ADDR_W-1:0] w_pred_target,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_ret_pred_valid,
  output logic [ADDR_W-1:0] f_ret_pred,
  output logic              f_ret_wait,
  output logic              f_halted,
  output logic              redirect
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pred_pc;
  logic [ADDR_W-1:0] pred_next;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              redir_w;
  logic              redir_m;
  logic              active;
  logic              adv;
  logic              push_req;
  logic              pop_req;
  logic              go_halt;

  // Correction mux: W return beats M jump beats prediction.
  always_comb begin
    redir_w  = (w_icode == I_RET) &&
               (!w_pred_valid || (w_pred_target != w_valM));
    redir_m  = (m_icode == I_JXX) && !m_cnd;
    redirect = redir_w || redir_m;
    f_pc     = pred_pc;
    if (redir_m) f_pc = m_valA;
    if (redir_w) f_pc = w_valM;
  end

  assign active = redirect || (state == RUN);

  // Next-PC prediction for the instruction at f_pc.
  always_comb begin
    pred_next  = f_valP;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    go_halt    = 1'b0;
    f_ret_wait = 1'b0;
    unique case (1'b1)
      active && (f_icode == I_JXX): begin
        pred_next = f_valC;
      end
      active && (f_icode == I_CALL): begin
        pred_next = f_valC;
        push_req  = 1'b1;
      end
      active && (f_icode == I_RET): begin
        if (!redirect && !ras_empty) begin
          pred_next = ras_top;
          pop_req   = 1'b1;
        end else begin
          f_ret_wait = 1'b1;
        end
      end
      active && (f_icode == I_HALT): begin
        pred_next = f_pc;
        go_halt   = 1'b1;
      end
      default: ;
    endcase
  end

  assign f_ret_pred_valid = pop_req;
  assign f_ret_pred       = ras_top;
  assign f_halted         = (state == HALT);
  assign adv = !redirect && !f_stall && (state == RUN);

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_req && adv),
    .pop  (pop_req && adv),
    .flush(redirect),
    .din  (f_valP),
    .top  (ras_top),
    .empty(ras_empty)
  );

  // Predicted PC and RUN/HALT state; a correction always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc <= RESET_PC;
      state   <= RUN;
    end else if (redirect) begin
      pred_pc <= pred_next;
      state   <= RUN;
    end else if (adv) begin
      pred_pc <= pred_next;
      if (go_halt) state <= HALT;
    end
  end

endmodule

// File: doc/pc_select_pred.md
# pc_select_pred

Fetch-stage PC selection and prediction unit for the pipelined Y86-64 core. It is the successor of the sequential PC-update block. It holds the predicted-PC register and picks each cycle's fetch address from three sources: prediction, jump-mispredict correction from M, or return correction from W. It adds a parametrised return-address stack (RAS) so `ret` can be predicted instead of always stalling, plus a HALT state that freezes fetch.

## Interface
- `ADDR_W`, 64, address/data width of all PC and value ports
- `RESET_PC`, 0, fetch address after reset
- `RAS_DEPTH`, 8, return-address stack entries (power of two, ≥2)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `f_stall`  in  1  hold fetch (from hazard unit)
- `f_icode`  in  4  icode of the instruction fetched at `f_pc`
- `f_valC`, `f_valP`  in  ADDR_W  constant word and fall-through address of that instruction
- `m_icode`  in  4, `m_cnd`  in  1, `m_valA`  in  ADDR_W  M-stage icode, condition, fall-through PC
- `w_icode`  in  4, `w_valM`  in  ADDR_W  W-stage icode and actual return address
- `w_pred_valid`  in  1, `w_pred_target`  in  ADDR_W  RAS prediction carried down with the W-stage `ret`
- `f_pc`  out  ADDR_W  fetch address (combinational)
- `f_ret_pred_valid`  out  1, `f_ret_pred`  out  ADDR_W  RAS prediction for the fetched `ret`, carried down the pipe
- `f_ret_wait`  out  1  fetched `ret` is unpredicted; hazard unit stalls fetch until W
- `f_halted`  out  1  unit is in HALT
- `redirect`  out  1  `f_pc` comes from M or W correction this cycle

## Operation
- Redirect sources, highest priority first:
  - **W ret:** `w_icode`=RET(9) and (`!w_pred_valid` or `w_pred_target`≠`w_valM`) → `f_pc`=`w_valM`.
  - **M jump:** `m_icode`=JXX(7) and `!m_cnd` → `f_pc`=`m_valA`.
  - **Otherwise:** `f_pc`=`pred_pc`.
- Next-PC prediction, for the instruction fetched at `f_pc`:
  - JXX → `f_valC`.
  - CALL(8) → `f_valC`, and push `f_valP` onto the RAS.
  - RET(9) with RAS non-empty → pop top; `f_ret_pred_valid`=1; `f_ret_pred`=top; prediction = top.
  - RET with RAS empty → `f_ret_wait`=1; prediction = `f_valP`.
  - HALT(0) → prediction = `f_pc`; state → HALT.
  - All other icodes → `f_valP`.
- Update rules:
  - `redirect`=1: `pred_pc` loads the prediction even if `f_stall`=1; the RAS is flushed (count=0, no push/pop this cycle); state → RUN.
  - No redirect and `f_stall`=1: `pred_pc`, RAS and state hold.
  - No redirect and `f_stall`=0: `pred_pc` ← prediction; push/pop applies.
- During a redirect cycle, `f_ret_pred_valid`=0. A RET fetched in that cycle reports `f_ret_wait`=1.
- State machine: RUN, HALT.
  - In HALT: `f_halted`=1; `pred_pc`/RAS are frozen and `f_icode` is ignored.
  - HALT exits to RUN only on `redirect`, because the halt was speculative.
- RAS behaviour:
  - Circular buffer with top pointer and saturating count (0..`RAS_DEPTH`).
  - Push when full overwrites the oldest entry; count stays at `RAS_DEPTH`.
  - Pop decrements count.
- Arithmetic: only equality compare and muxing on `ADDR_W`; no adders (`f_valP` is supplied).

## Timing
- `f_pc`, `redirect`, `f_ret_*` and `f_ret_wait` are combinational from inputs and registers, with zero latency.
- `pred_pc`, RAS and state update on the rising `clk`; a prediction is visible as `f_pc` one cycle later.
- Reset, asynchronous on `rst_n` low: `pred_pc`=`RESET_PC`, RAS count=0, pointer=0, state=RUN.
  - Hence `f_pc`=`RESET_PC`, `f_halted`=0, and `redirect`=0 when M/W icodes are NOP.
- Reset mid-operation discards every RAS entry and any HALT state immediately.

## Structure
- Shared package `y86_pkg`: icode constants (HALT, NOP, JXX, CALL, RET, …) and the `fetch_state_t` enum {RUN, HALT}. Add it if absent.
- Sub-module `ras_stack`: parameters (`ADDR_W`, `RAS_DEPTH`); ports push, pop, flush, data in, top, empty.
- Top level holds `pred_pc`, the FSM and the redirect mux.

## Test plan
- **Reset/sequential:** release `rst_n`, `f_icode`=NOP, `f_valP`=0x0A → cycle 0 `f_pc`=0x00, cycle 1 `f_pc`=0x0A.
- **Call/ret predicted:** CALL `f_valC`=0x40 `f_valP`=0x13, then RET → `f_pc`=0x40, then `f_ret_pred_valid`=1, `f_ret_pred`=0x13, next `f_pc`=0x13; W RET `w_valM`=0x13 `w_pred_valid`=1 `w_pred_target`=0x13 → `redirect`=0.
- **Jump mispredict:** JXX `f_valC`=0x06 → `f_pc`=0x06; later `m_icode`=7 `m_cnd`=0 `m_valA`=0x09 → `f_pc`=0x09, `redirect`=1, RAS flushed. Repeat with `f_stall`=1 → still redirects.
- **Empty RAS / mismatch:** RET with RAS empty → `f_ret_wait`=1. W RET `w_valM`=0x20 with `w_pred_target`=0x30 while M mispredicts to 0x50 → `f_pc`=0x20 (W wins).
- **RAS overflow (`RAS_DEPTH`=8):** 9 CALLs with `f_valP` 0x100..0x108, then 9 RETs → predictions 0x108..0x101, 9th RET `f_ret_wait`=1.
- **Halt:** HALT fetched at 0x30 → `f_halted`=1, `f_pc` stays 0x30 under any `f_icode`; M mispredict to 0x38 → RUN, `f_pc`=0x38.
